// File: rtl/instruction_decode_if.sv
// instruction_decode_if: fetch, writeback, debug and ID/EX signals of the decode stage
interface instruction_decode_if;
   logic [31:0] pc;
   logic [31:0] ir;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        branch;
   logic [31:0] branch_addr;
   logic        jump;
   logic [31:0] jump_addr;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_rs_data;
   logic [31:0] ex_rt_data;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rd;
   logic [1:0]  ex_alu_op;
   logic        ex_alu_src;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_reg_write;
   logic        illegal;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   modport master (
      output pc, ir, wb_we, wb_addr, wb_data, dbg_addr,
      input  branch, branch_addr, jump, jump_addr, ex_valid, ex_pc, ex_rs_data, ex_rt_data,
             ex_imm, ex_rd, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
             illegal, dbg_data
   );
   modport slave (
      input  pc, ir, wb_we, wb_addr, wb_data, dbg_addr,
      output branch, branch_addr, jump, jump_addr, ex_valid, ex_pc, ex_rs_data, ex_rt_data,
             ex_imm, ex_rd, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
             illegal, dbg_data
   );
endinterface

// File: rtl/instruction_decode.sv
// instruction_decode: ID stage with register file, bypass, branch resolution, squash and ID/EX register
module instruction_decode #(
   parameter int NREG   = 32,
   parameter int SQUASH = 1
) (
   input logic clk,
   input logic rst,
   instruction_decode_if.slave id
);
   logic [31:0] regs [NREG];
   logic [1:0]  cnt;
   logic [5:0]  op, fn;
   logic [4:0]  rs, rt, rd, dest;
   logic [31:0] rs_data, rt_data, imm;
   logic        is_r, is_lw, is_sw, is_beq, is_bne, is_j, legal, squashed, live, eq;
   logic [1:0]  alu_op;
   assign op = id.ir[31:26];
   assign fn = id.ir[5:0];
   assign rs = id.ir[25:21];
   assign rt = id.ir[20:16];
   assign rd = id.ir[15:11];
   assign imm = {{16{id.ir[15]}}, id.ir[15:0]};
   // write-through bypass; $0 is never written so it always reads zero
   assign rs_data = (id.wb_we && id.wb_addr == rs && id.wb_addr != 5'd0) ? id.wb_data : regs[rs];
   assign rt_data = (id.wb_we && id.wb_addr == rt && id.wb_addr != 5'd0) ? id.wb_data : regs[rt];
   assign is_r = op == 6'b000000 && (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b101010);
   assign is_lw = op == 6'b100011;
   assign is_sw = op == 6'b101011;
   assign is_beq = op == 6'b000100;
   assign is_bne = op == 6'b000101;
   assign is_j = op == 6'b000010;
   assign legal = is_r | is_lw | is_sw | is_beq | is_bne | is_j;
   assign squashed = cnt != 2'd0;
   assign live = legal && !squashed;
   assign eq = rs_data == rt_data;
   assign dest = is_r ? rd : is_lw ? rt : 5'd0;
   assign alu_op = !is_r ? 2'd0 : fn == 6'b100010 ? 2'd1 : fn == 6'b101010 ? 2'd2 : 2'd0;
   assign id.branch = !squashed && ((is_beq && eq) || (is_bne && !eq));
   assign id.jump = !squashed && is_j;
   assign id.branch_addr = id.pc + {imm[29:0], 2'b00};
   assign id.jump_addr = {id.pc[31:28], id.ir[25:0], 2'b00};
   assign id.dbg_data = regs[id.dbg_addr];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         cnt <= '0;
         id.ex_valid <= 1'b0;
         id.ex_pc <= '0;
         id.ex_rs_data <= '0;
         id.ex_rt_data <= '0;
         id.ex_imm <= '0;
         id.ex_rd <= '0;
         id.ex_alu_op <= '0;
         id.ex_alu_src <= 1'b0;
         id.ex_mem_read <= 1'b0;
         id.ex_mem_write <= 1'b0;
         id.ex_reg_write <= 1'b0;
         id.illegal <= 1'b0;
      end else begin
         if (id.wb_we && id.wb_addr != 5'd0) regs[id.wb_addr] <= id.wb_data;
         cnt <= (id.branch || id.jump) ? 2'(SQUASH) : cnt - 2'(squashed);
         id.ex_valid <= live;
         id.ex_pc <= live ? id.pc : '0;
         id.ex_rs_data <= live ? rs_data : '0;
         id.ex_rt_data <= live ? rt_data : '0;
         id.ex_imm <= live ? imm : '0;
         id.ex_rd <= live ? dest : '0;
         id.ex_alu_op <= live ? alu_op : '0;
         id.ex_alu_src <= live && (is_lw || is_sw);
         id.ex_mem_read <= live && is_lw;
         id.ex_mem_write <= live && is_sw;
         id.ex_reg_write <= live && (is_r || is_lw) && dest != 5'd0;
         id.illegal <= !squashed && !legal;
      end
   end
endmodule
